// File: rtl/photon_cnt_pkg.sv
// Shared types and helpers for the gated photon counter.
// Provides the state encoding, the default sizes and a saturating increment.
package photon_cnt_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_GATE_W   = 24;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        COUNT = S_COUNT,
        HOLD  = S_HOLD
    } state_t;

    // Holds at maxv instead of wrapping; callers keep widths <= 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/photon_edge_sync.sv
// Synchroniser chain plus rising-edge detector for one asynchronous pulse line.
// rise_o is high for one cycle, SYNC_STAGES cycles after the new level is first sampled.
module photon_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/photon_gate_counter.sv
// Multi-channel gated photon counter; results held until taken with valid/ready (start ignored while held).
// PHOTON_CNT_CONTINUOUS_EN: back-to-back gates with no dead time, overrun flags an unread overwrite.
module photon_gate_counter
    import photon_cnt_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int GATE_W      = DEF_GATE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk50Mhz,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       sig,
    input  logic                      start,
    input  logic                      abort,
    input  logic [GATE_W-1:0]         gate_cycles,
    output logic                      busy,
    output logic [CHANNELS*WIDTH-1:0] cnt,
    output logic [CHANNELS-1:0]       sat,
    output logic                      valid,
    input  logic                      ready,
    output logic                      overrun
);

    localparam logic [WIDTH-1:0] MAXV = '1;

    state_t                           state_q;
    logic [GATE_W-1:0]                timer_q;
    logic [CHANNELS-1:0][WIDTH-1:0]   run_q;
    logic [CHANNELS-1:0][WIDTH-1:0]   run_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   cnt_q;
    logic [CHANNELS-1:0]              sat_q;
    logic [CHANNELS-1:0]              sat_d;
    logic                             valid_q;
    logic [CHANNELS-1:0]              rise;
    logic                             handshake;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_sync
        photon_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk_i  (clk50Mhz),
            .rst_i  (rst),
            .sig_i  (sig[k]),
            .rise_o (rise[k])
        );
    end

    // Running counts including this cycle's edges, so the last gate cycle is latched in full.
    always_comb begin
        run_d = run_q;
        sat_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (rise[k]) begin
                run_d[k] = WIDTH'(sat_inc(32'(run_q[k]), 32'(MAXV)));
            end
            sat_d[k] = (run_d[k] == MAXV);
        end
    end

    assign handshake = valid_q && ready;

`ifdef PHOTON_CNT_CONTINUOUS_EN
    logic overrun_q;
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

    always_ff @(posedge clk50Mhz) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            run_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= '0;
            valid_q <= 1'b0;
`ifdef PHOTON_CNT_CONTINUOUS_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            if (handshake) begin
                valid_q <= 1'b0;
            end
            if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && gate_cycles != '0) begin
                            state_q <= COUNT;
                            timer_q <= gate_cycles;
                            run_q   <= '0;
`ifdef PHOTON_CNT_CONTINUOUS_EN
                            overrun_q <= 1'b0;
`endif
                        end
                    end
                    COUNT: begin
                        run_q   <= run_d;
                        timer_q <= timer_q - GATE_W'(1);
                        if (timer_q == GATE_W'(1)) begin
                            cnt_q   <= run_d;
                            sat_q   <= sat_d;
                            valid_q <= 1'b1;
`ifdef PHOTON_CNT_CONTINUOUS_EN
                            if (valid_q && !ready) begin
                                overrun_q <= 1'b1;
                            end
                            run_q   <= '0;
                            timer_q <= gate_cycles;
                            if (gate_cycles == '0) begin
                                state_q <= IDLE;
                            end
`else
                            state_q <= HOLD;
`endif
                        end
                    end
                    HOLD: begin
                        if (handshake) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy  = (state_q == COUNT);
    assign cnt   = cnt_q;
    assign sat   = sat_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_photon_gate_counter.sv
// Bench for photon_gate_counter: a 16-bit and a 4-bit instance share one stimulus and are
// checked every cycle against a window-sum model of the gated edge counts.
module tb_photon_gate_counter;

    localparam int S  = 2;
    localparam int NH = 16384;

    logic        clk = 1'b0;
    logic        rst, start, abort, ready;
    logic [1:0]  sig;
    logic [23:0] gate;

    logic        busy_a, valid_a, ovr_a, busy_b, valid_b, ovr_b;
    logic [31:0] cnt_a;
    logic [7:0]  cnt_b;
    logic [1:0]  sat_a, sat_b;

    photon_gate_counter #(.WIDTH(16)) dut_a (
        .clk50Mhz(clk), .rst(rst), .sig(sig), .start(start), .abort(abort),
        .gate_cycles(gate), .busy(busy_a), .cnt(cnt_a), .sat(sat_a),
        .valid(valid_a), .ready(ready), .overrun(ovr_a)
    );

    photon_gate_counter #(.WIDTH(4)) dut_b (
        .clk50Mhz(clk), .rst(rst), .sig(sig), .start(start), .abort(abort),
        .gate_cycles(gate), .busy(busy_b), .cnt(cnt_b), .sat(sat_b),
        .valid(valid_b), .ready(ready), .overrun(ovr_b)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Model: input history plus gate windows; a count is the number of sampled 0->1 edges in the window.
    logic [1:0] hist [NH];
    int  cyc = 0;
    int  last_rst = -1;
    bit  gate_on, hold, e_valid, e_ovr;
    int  gs, ge;
    int  e_cnt [2];

    function automatic bit hbit(input int j, input int k);
        if (j <= last_rst || j < 0) return 1'b0;
        return hist[j][k];
    endfunction

    function automatic int edges_in(input int k, input int from, input int to);
        int n = 0;
        for (int c = from; c <= to; c++) begin
            if (hbit(c - S + 1, k) && !hbit(c - S, k)) n++;
        end
        return n;
    endfunction

    function automatic longint capv(input int raw, input int w);
        longint m = (longint'(1) << w) - 1;
        return (raw > m) ? m : raw;
    endfunction

    always @(posedge clk) begin
        bit hs, latched;
        cyc++;
        if (cyc >= NH) begin
            $display("FAIL history_overflow cycle %0d limit %0d", cyc, NH);
            $fatal(1);
        end
        hist[cyc] = sig;
        if (rst) begin
            gate_on = 0; hold = 0; e_valid = 0; e_ovr = 0;
            e_cnt[0] = 0; e_cnt[1] = 0;
            last_rst = cyc;
        end else begin
            hs = e_valid && ready;
            latched = 0;
            if (abort) begin
                gate_on = 0;
                hold = 0;
            end else if (gate_on && cyc == ge) begin
                for (int k = 0; k < 2; k++) e_cnt[k] = edges_in(k, gs, ge - 1);
                latched = 1;
`ifdef PHOTON_CNT_CONTINUOUS_EN
                if (e_valid && !ready) e_ovr = 1;
                if (gate != 0) begin gs = cyc; ge = cyc + int'(gate); end
                else gate_on = 0;
`else
                gate_on = 0;
                hold = 1;
`endif
            end else if (!gate_on && !hold && start && gate != 0) begin
                gate_on = 1; gs = cyc; ge = cyc + int'(gate); e_ovr = 0;
            end
            if (hs && !latched) begin e_valid = 0; hold = 0; end
            if (latched) e_valid = 1;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("busy_a", busy_a, gate_on);
            chk("busy_b", busy_b, gate_on);
            chk("valid_a", valid_a, e_valid);
            chk("valid_b", valid_b, e_valid);
            chk("overrun_a", ovr_a, e_ovr);
            chk("overrun_b", ovr_b, e_ovr);
            for (int k = 0; k < 2; k++) begin
                chk("cnt_a", cnt_a[k*16 +: 16], capv(e_cnt[k], 16));
                chk("sat_a", sat_a[k], longint'(e_cnt[k] >= 65535));
                chk("cnt_b", cnt_b[k*4 +: 4], capv(e_cnt[k], 4));
                chk("sat_b", sat_b[k], longint'(e_cnt[k] >= 15));
            end
        end
    end

    // Called at a negedge; ch0 gets nper pulses of period per starting at loop index first.
    task automatic run_gate(input int gc, input int first, input int nper, input int per,
                            input int abort_at, output int busy_n);
        busy_n = 0;
        start = 1'b1;
        gate  = 24'(gc);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < gc + 3; i++) begin
            sig[0] = (i >= first && i < first + nper * per && ((i - first) % per) < per / 2);
            abort  = (i == abort_at);
            if (busy_a) busy_n++;
            @(negedge clk);
        end
        sig   = '0;
        abort = 1'b0;
    endtask

    task automatic take_result();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        int bn, c1, c2;
        rst = 1'b1; sig = '0; start = 1'b0; abort = 1'b0; ready = 1'b0; gate = '0;
        repeat (3) @(negedge clk);
        chk("t1_cnt", cnt_a, 0);
        chk("t1_sat", sat_a, 0);
        chk("t1_valid", valid_a, 0);
        chk("t1_busy", busy_a, 0);
        chk("t1_overrun", ovr_a, 0);
        rst = 1'b0;
        @(negedge clk);

`ifdef PHOTON_CNT_CONTINUOUS_EN
        start = 1'b1; gate = 24'd20;
        @(negedge clk);
        start = 1'b0;
        c1 = 0; c2 = 0;
        for (int i = 0; i <= 60; i++) begin
            if (i == 20) c1 = int'(cnt_a[15:0]);
            if (i == 40) c2 = int'(cnt_a[15:0]);
            if (i == 60) begin
                chk("t6_overrun", ovr_a, 1);
                chk("t6_cnt_gate3", cnt_a[15:0], 2);
                chk("t6_total_edges", c1 + c2 + int'(cnt_a[15:0]), 5);
            end
            sig[0] = (i >= 17 && ((i - 17) % 10) < 5);
            @(negedge clk);
        end
        sig = '0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_busy_after_abort", busy_a, 0);
        take_result();
`else
        run_gate(100, 0, 7, 10, -1, bn);
        chk("t2_busy_cycles", bn, 100);
        chk("t2_valid", valid_a, 1);
        chk("t2_cnt0", cnt_a[15:0], 7);
        chk("t2_cnt1", cnt_a[31:16], 0);
        take_result();
        chk("t2_valid_cleared", valid_a, 0);
        chk("t2_idle", busy_a, 0);

        run_gate(200, 0, 20, 6, -1, bn);
        chk("t3_cnt_w4", cnt_b[3:0], 15);
        chk("t3_sat_w4", sat_b[0], 1);
        chk("t3_cnt_w16", cnt_a[15:0], 20);
        take_result();
        run_gate(50, 0, 3, 6, -1, bn);
        chk("t3_cnt2_w4", cnt_b[3:0], 3);
        chk("t3_sat2_w4", sat_b[0], 0);
        take_result();

        start = 1'b1; gate = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            chk("t4_zero_gate_busy", busy_a, 0);
            @(negedge clk);
        end
        run_gate(30, 27, 1, 20, -1, bn);
        chk("t4_last_cycle_edge", cnt_a[15:0], 1);
        take_result();
        run_gate(30, 28, 1, 20, -1, bn);
        chk("t4_after_gate_edge", cnt_a[15:0], 0);
        take_result();

        run_gate(40, 0, 4, 6, -1, bn);
        chk("t5_first_result", cnt_a[15:0], 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_hold_abort_valid", valid_a, 1);
        run_gate(100, 0, 9, 10, 50, bn);
        chk("t5_abort_busy_cycles", bn, 51);
        chk("t5_abort_idle", busy_a, 0);
        chk("t5_abort_valid", valid_a, 1);
        chk("t5_abort_cnt", cnt_a[15:0], 4);
        start = 1'b1; gate = 24'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_busy", busy_a, 0);
        chk("t5_rst_valid", valid_a, 0);
        chk("t5_rst_cnt", cnt_a, 0);
        chk("t5_rst_sat", sat_a, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 2) == 0) sig[k] = ~sig[k];
            end
            start = ($urandom_range(0, 15) == 0);
            gate  = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom_range(1, 40));
            abort = ($urandom_range(0, 63) == 0);
            ready = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0; sig = '0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
